// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 16-bit MIPS pipeline. Owns the PC, drives a synchronous
// instruction memory and hands one registered word per cycle to decode.
// It redirects locally on JMP and on resolved branches from downstream, holds
// while downstream stalls, and inserts NOP bubbles (32'h0) on redirects.
// Optional feature: define IFU_PERF_CNT_EN to build the fetched/bubble
// performance counters; otherwise both counters read as constant zero.
//
// state | meaning
// FILL  | first cycle after reset, nothing in flight yet
// RUN   | streaming: one word issued and one delivered per edge
// HOLD  | downstream stall, all fetch registers frozen
// HALT  | halt opcode delivered, fetch stopped until reset
module instruction_fetch_unit #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [5:0]      HALT_OP  = 6'b111111
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic            imem_en,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     ins,
  output logic            ins_valid,
  output logic [PC_W-1:0] ins_pc,
  output logic            halted,
  output logic [15:0]     perf_fetched,
  output logic [15:0]     perf_bubbles
);

  localparam logic [5:0] JMP_OP = 6'b011000;

  typedef enum logic [1:0] {ST_FILL, ST_RUN, ST_HOLD, ST_HALT} state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] rd_pc_q, rd_pc_d;
  logic            rd_valid_q, rd_valid_d;
  logic [31:0]     ins_q, ins_d;
  logic            ins_valid_q, ins_valid_d;
  logic [PC_W-1:0] ins_pc_q, ins_pc_d;
  logic            halted_q, halted_d;
  logic            is_jmp, is_halt;

  // Squashed data (rd_valid low) is never decoded as JMP or HALT.
  assign is_jmp  = rd_valid_q && (imem_rdata[31:26] == JMP_OP);
  assign is_halt = rd_valid_q && (imem_rdata[31:26] == HALT_OP);

  // State and datapath registers, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_FILL;
      pc_q        <= RESET_PC;
      rd_pc_q     <= '0;
      rd_valid_q  <= 1'b0;
      ins_q       <= '0;
      ins_valid_q <= 1'b0;
      ins_pc_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rd_pc_q     <= rd_pc_d;
      rd_valid_q  <= rd_valid_d;
      ins_q       <= ins_d;
      ins_valid_q <= ins_valid_d;
      ins_pc_q    <= ins_pc_d;
      halted_q    <= halted_d;
    end
  end

  // Next state: branch beats stall, stall beats HALT decode; HALT is sticky.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: begin
        if (branch_taken || !stall) state_d = ST_RUN;
      end
      ST_RUN, ST_HOLD: begin
        if (branch_taken)  state_d = ST_RUN;
        else if (stall)    state_d = ST_HOLD;
        else if (is_halt)  state_d = ST_HALT;
        else               state_d = ST_RUN;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FILL;
    endcase
  end

  // Datapath update; a stalled edge leaves everything untouched, and the
  // edge that releases a stall is an ordinary streaming edge.
  always_comb begin
    pc_d        = pc_q;
    rd_pc_d     = rd_pc_q;
    rd_valid_d  = rd_valid_q;
    ins_d       = ins_q;
    ins_valid_d = ins_valid_q;
    ins_pc_d    = ins_pc_q;
    halted_d    = halted_q;
    if (state_q == ST_HALT) begin
      ins_d       = '0;
      ins_valid_d = 1'b0;
      halted_d    = 1'b1;
    end else if (branch_taken) begin
      pc_d        = branch_target;
      rd_valid_d  = 1'b0;
      ins_d       = '0;
      ins_valid_d = 1'b0;
    end else if (!stall) begin
      ins_d       = rd_valid_q ? imem_rdata : '0;
      ins_valid_d = rd_valid_q;
      ins_pc_d    = rd_pc_q;
      rd_pc_d     = pc_q;
      if (is_jmp) begin
        // The sequential word issued this cycle is dropped: one bubble.
        pc_d       = imem_rdata[PC_W-1:0];
        rd_valid_d = 1'b0;
      end else begin
        pc_d       = pc_q + PC_W'(1);
        rd_valid_d = 1'b1;
      end
    end
  end

  // Outputs: imem reads whenever fetch is neither stalled nor halted.
  always_comb begin
    imem_en   = !stall && (state_q != ST_HALT);
    imem_addr = pc_q;
    ins       = ins_q;
    ins_valid = ins_valid_q;
    ins_pc    = ins_pc_q;
    halted    = halted_q;
  end

`ifdef IFU_PERF_CNT_EN
  logic [15:0] perf_fetched_q, perf_fetched_d;
  logic [15:0] perf_bubbles_q, perf_bubbles_d;
  logic        load_word, load_nop;

  assign load_word = (state_q != ST_HALT) && !branch_taken && !stall && rd_valid_q;
  assign load_nop  = (state_q != ST_HALT) && (branch_taken || (!stall && !rd_valid_q));

  // Saturating event counters for delivered words and bubbles.
  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (load_word && (perf_fetched_q != 16'hFFFF)) perf_fetched_d = perf_fetched_q + 16'd1;
    if (load_nop  && (perf_bubbles_q != 16'hFFFF)) perf_bubbles_d = perf_bubbles_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`else
  assign perf_fetched = 16'h0;
  assign perf_bubbles = 16'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal
// expectations, then randomized stall/branch/reset traffic over random
// program memory, all checked every cycle against a stream-level model.
module tb_instruction_fetch_unit;

  localparam logic [5:0] JMP  = 6'b011000;
  localparam logic [5:0] HALT = 6'b111111;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [15:0] branch_target;
  logic        imem_en;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic [15:0] ins_pc;
  logic        halted;
  logic [15:0] perf_fetched, perf_bubbles;

  logic [31:0] mem [0:65535];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model state: next address to issue, the address in flight, delivered word.
  logic [15:0] m_next, m_fly_addr, m_ins_pc;
  logic        m_fly_valid, m_valid, m_halt, m_halted;
  logic [31:0] m_ins;
  int          m_fetched, m_bubbles;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .ins(ins), .ins_valid(ins_valid), .ins_pc(ins_pc),
    .halted(halted), .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [31:0] w;
    logic        jmp;
    w   = '0;
    jmp = 1'b0;
    if (reset) begin
      m_next = 16'h0000; m_fly_addr = '0; m_fly_valid = 1'b0;
      m_ins = '0; m_valid = 1'b0; m_ins_pc = '0;
      m_halt = 1'b0; m_halted = 1'b0; m_fetched = 0; m_bubbles = 0;
    end else if (m_halt) begin
      m_ins = '0; m_valid = 1'b0; m_halted = 1'b1;
    end else if (branch_taken) begin
      m_next = branch_target; m_fly_valid = 1'b0;
      m_ins = '0; m_valid = 1'b0;
      if (m_bubbles < 65535) m_bubbles++;
    end else if (!stall) begin
      if (m_fly_valid) begin
        w = mem[m_fly_addr];
        m_ins = w; m_valid = 1'b1; m_ins_pc = m_fly_addr;
        if (m_fetched < 65535) m_fetched++;
        if (w[31:26] == HALT) m_halt = 1'b1;
        else if (w[31:26] == JMP) jmp = 1'b1;
      end else begin
        m_ins = '0; m_valid = 1'b0;
        if (m_bubbles < 65535) m_bubbles++;
      end
      m_fly_addr  = m_next;
      m_fly_valid = !jmp;
      m_next      = jmp ? w[15:0] : m_next + 16'd1;
    end
  endtask

  // One clock: the model sees the same inputs the DUT samples at this edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int r;
    w = $urandom;
    r = $urandom_range(0, 99);
    if (r < 10)      w[31:26] = JMP;
    else if (r < 11) w[31:26] = HALT;
    else if (w[31:26] == JMP || w[31:26] == HALT) w[31:26] = 6'b000001;
    return w;
  endfunction

  // Per-cycle comparison of every meaningful output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ins", ins, m_ins);
      chk("ins_valid", {31'b0, ins_valid}, {31'b0, m_valid});
      if (m_valid) chk("ins_pc", {16'b0, ins_pc}, {16'b0, m_ins_pc});
      chk("halted", {31'b0, halted}, {31'b0, m_halted});
      chk("imem_en", {31'b0, imem_en}, {31'b0, (!stall && !m_halt)});
      if (!m_halt) chk("imem_addr", {16'b0, imem_addr}, {16'b0, m_next});
`ifdef IFU_PERF_CNT_EN
      chk("perf_fetched", {16'b0, perf_fetched}, m_fetched);
      chk("perf_bubbles", {16'b0, perf_bubbles}, m_bubbles);
`else
      chk("perf_fetched", {16'b0, perf_fetched}, 32'h0);
      chk("perf_bubbles", {16'b0, perf_bubbles}, 32'h0);
`endif
    end
  end

  initial begin
    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'h1000_0000 + i;
    mem[3] = 32'h6000_0040;

    // Reset, sequential stream, JMP bubble, stall hold.
    tick(); tick();
    chk_en = 1'b1;
    chk("rst_ins", ins, 32'h0);
    chk("rst_valid", {31'b0, ins_valid}, 32'h0);
    chk("rst_halted", {31'b0, halted}, 32'h0);
    chk("rst_addr", {16'b0, imem_addr}, 32'h0);
    reset = 1'b0;
    tick();
    chk("fill_valid", {31'b0, ins_valid}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("seq_pc", {16'b0, ins_pc}, i);
      chk("seq_ins", ins, 32'h1000_0000 + i);
    end
    tick();
    chk("jmp_word", ins, 32'h6000_0040);
    chk("jmp_pc", {16'b0, ins_pc}, 32'h3);
    tick();
    chk("jmp_bubble", {31'b0, ins_valid}, 32'h0);
    chk("jmp_bubble_ins", ins, 32'h0);
    tick();
    chk("jmp_target", {16'b0, ins_pc}, 32'h40);
    tick();
    chk("pre_stall", ins, 32'h1000_0041);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ins", ins, 32'h1000_0041);
      chk("stall_en", {31'b0, imem_en}, 32'h0);
    end
    stall = 1'b0;
    tick();
    chk("post_stall", ins, 32'h1000_0042);

    // Branch together with stall: two bubbles then the target.
    branch_taken = 1'b1; branch_target = 16'h0020; stall = 1'b1;
    tick();
    chk("br_nop1", {31'b0, ins_valid}, 32'h0);
    branch_taken = 1'b0; stall = 1'b0;
    tick();
    chk("br_nop2", {31'b0, ins_valid}, 32'h0);
    tick();
    chk("br_target", {16'b0, ins_pc}, 32'h20);
    chk("br_word", ins, 32'h1000_0020);

    // PC wrap across 16'hFFFF.
    branch_taken = 1'b1; branch_target = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    tick(); tick();
    chk("wrap_fffe", {16'b0, ins_pc}, 32'hFFFE);
    tick();
    chk("wrap_ffff", {16'b0, ins_pc}, 32'hFFFF);
    tick();
    chk("wrap_0000", {16'b0, ins_pc}, 32'h0);
    chk("wrap_word", ins, 32'h1000_0000);

    // HALT at address 4.
    mem[3] = 32'h1000_0003;
    mem[4] = 32'hFC00_0000;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (5) tick();
    tick();
    chk("halt_word", ins, 32'hFC00_0000);
    chk("halt_not_yet", {31'b0, halted}, 32'h0);
    tick();
    chk("halted", {31'b0, halted}, 32'h1);
    chk("halt_ins", ins, 32'h0);
    chk("halt_en", {31'b0, imem_en}, 32'h0);
`ifdef IFU_PERF_CNT_EN
    chk("halt_fetched", {16'b0, perf_fetched}, 32'd5);
    chk("halt_bubbles", {16'b0, perf_bubbles}, 32'd1);
`endif
    branch_taken = 1'b1; branch_target = 16'h0010;
    tick();
    branch_taken = 1'b0;
    tick();
    chk("halt_sticky", {31'b0, halted}, 32'h1);
    chk("halt_sticky_valid", {31'b0, ins_valid}, 32'h0);

    // Randomized traffic over random program memory.
    reset = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = rand_word();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      stall         = ($urandom_range(0, 99) < 20);
      branch_taken  = ($urandom_range(0, 99) < 6);
      branch_target = 16'($urandom);
      reset         = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
